// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: staggers the power-on release of NUM_DOM
// active-low domain resets and re-runs the same release for soft-reset requests.
module reset_sequencer #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic [NUM_DOM-1:0] soft_req,
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic [NUM_DOM-1:0] soft_ack,
  output logic               busy,
  output logic               all_ready,
  output logic [1:0]         state_dbg
);

  // soft_req/soft_ack form a four-phase pair: a request bit is accepted only
  // while its ack is low; the ack rises when that domain's sequence completes
  // and falls one edge after the request drops, and only then may it re-arm.
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DOM-1:0] mask_q, mask_d;
  logic [NUM_DOM-1:0] rst_n_q, rst_n_d;
  logic [NUM_DOM-1:0] ack_q, ack_d;
  logic               soft_q, soft_d;

  logic [NUM_DOM-1:0] pend;
  logic [NUM_DOM-1:0] next_bit;
  logic [NUM_DOM-1:0] new_req;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last;
  logic               fire;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      mask_q  <= '1;
      rst_n_q <= '0;
      ack_q   <= '0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rst_n_q <= rst_n_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
    end
  end

  // Domains still waiting are masked ones whose reset is held low; the next
  // release is always the lowest such index.
  always_comb begin
    pend     = mask_q & ~rst_n_q;
    next_bit = pend & (~pend + NUM_DOM'(1));
    last     = ((pend & ~next_bit) == '0);
    cnt_inc  = cnt_q + CNT_W'(1);
    new_req  = soft_req & ~ack_q;
    fire     = 1'b0;

    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    rst_n_d = rst_n_q;
    ack_d   = ack_q;
    soft_d  = soft_q;

    case (state_q)
      S_HOLD: begin
        cnt_d = cnt_inc;
        fire  = (cnt_inc == CNT_W'(HOLD_CYCLES));
      end
      S_STEP: begin
        cnt_d = cnt_inc;
        fire  = (cnt_inc == CNT_W'(STEP_CYCLES));
      end
      S_RUN: begin
        ack_d = ack_q & soft_req;
        if (new_req != '0) begin
          mask_d  = new_req;
          rst_n_d = rst_n_q & ~new_req;
          cnt_d   = '0;
          soft_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (fire) begin
      rst_n_d = rst_n_q | next_bit;
      cnt_d   = '0;
      state_d = S_STEP;
      if (last) begin
        state_d = S_RUN;
        soft_d  = 1'b0;
        if (soft_q) ack_d = ack_q | mask_q;
      end
    end
  end

  assign rst_n_out = rst_n_q;
  assign soft_ack  = ack_q;
  assign busy      = (state_q != S_RUN);
  assign all_ready = (state_q == S_RUN);
  assign state_dbg = state_q;

endmodule
